polar_to_rect: RTL and testbench

Iterative CORDIC rotator that converts a polar sample (unsigned magnitude plus phase) into signed rectangular components I and Q. It is the inverse of the magnitude path, which turns (I, Q) into sqrt(I²+Q²). It regenerates I/Q from magnitude/phase pairs for synthesis and round-trip checks of the magnitude pipeline. It uses the same one-cycle input_ready/output_ready strobe convention, but it is a multi-cycle block and exposes a busy flag.

---
 rtl/polar_pkg.sv | 26 ++
 rtl/polar_to_rect.sv | 134 +++++++++++++
 tb/tb_polar_to_rect.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared types and constants for the polar-to-rectangular CORDIC rotator
package polar_pkg;

  localparam int PHASE_BITS   = 16;
  localparam int ATAN_ENTRIES = 16;

  typedef logic [PHASE_BITS-1:0] phase_t;

  // Prescale by 1/K so the CORDIC gain cancels: m' = (m * K_INV) >> K_INV_SHIFT
  localparam int K_INV       = 19898;
  localparam int K_INV_SHIFT = 15;

  // z carries extra fractional bits below the phase LSB so the table rounding
  // does not accumulate into a visible angle error at full-scale magnitudes.
  localparam int Z_FRAC_BITS = 8;
  localparam int Z_BITS      = PHASE_BITS + Z_FRAC_BITS + 1;

  // round(atan(2^-i) * 2^(PHASE_BITS+Z_FRAC_BITS) / 2pi); entry 0 is 8192 phase LSBs
  localparam int ATAN [0:ATAN_ENTRIES-1] = '{
    2097152, 1238021, 654136, 332050, 166669, 83416, 41718, 20860,
    10430,   5215,    2608,   1304,   652,    326,   163,   81
  };

  typedef enum logic [1:0] {IDLE, PRESCALE, ROTATE, DONE} state_t;

endpackage

// File: rtl/polar_to_rect.sv
// rtl/polar_to_rect.sv - iterative CORDIC rotator converting (magnitude, phase) to signed I/Q
module polar_to_rect
  import polar_pkg::*;
#(
  parameter int MAG_BITS    = 17,
  parameter int ITERATIONS  = 16,
  parameter int GUARD_BITS  = 2,
  parameter int OUTPUT_BITS = MAG_BITS + 1,
  parameter int WORK_BITS   = OUTPUT_BITS + GUARD_BITS + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_ready,
  input  logic [MAG_BITS-1:0]    magnitude,
  input  logic [PHASE_BITS-1:0]  phase,
  output logic                   busy,
  output logic                   output_ready,
  output logic [OUTPUT_BITS-1:0] output_1,
  output logic [OUTPUT_BITS-1:0] output_2
);

  localparam int PROD_BITS = MAG_BITS + K_INV_SHIFT;
  localparam int ITER_W    = $clog2(ITERATIONS);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERATIONS - 1);
  localparam logic signed [WORK_BITS-1:0] OUT_MAX = WORK_BITS'((1 << (OUTPUT_BITS - 1)) - 1);
  localparam logic signed [WORK_BITS-1:0] OUT_MIN = ~OUT_MAX;

  state_t                       state_q;
  logic [MAG_BITS-1:0]          mag_q;
  phase_t                       phase_q;
  logic signed [WORK_BITS-1:0]  x_q, y_q;
  logic signed [Z_BITS-1:0]     z_q;
  logic [ITER_W-1:0]            iter_q;
  logic                         busy_q, ready_q;
  logic [OUTPUT_BITS-1:0]       out1_q, out2_q;

  logic [PROD_BITS-1:0]         prod;
  logic signed [WORK_BITS-1:0]  m_g, x0;
  logic                         fold;
  phase_t                       z_ph;
  logic signed [Z_BITS-1:0]     z0;
  logic signed [WORK_BITS-1:0]  x_sh, y_sh, x_d, y_d;
  logic signed [Z_BITS-1:0]     atan_step, z_d;

  function automatic logic [OUTPUT_BITS-1:0] sat_out(input logic signed [WORK_BITS-1:0] v);
    logic signed [WORK_BITS-1:0] s;
    s = v >>> GUARD_BITS;
    if (s > OUT_MAX) return OUTPUT_BITS'(OUT_MAX);
    if (s < OUT_MIN) return OUTPUT_BITS'(OUT_MIN);
    return OUTPUT_BITS'(s);
  endfunction

  always_comb begin
    // Prescaled magnitude keeps GUARD_BITS fractional bits instead of dropping them
    prod = PROD_BITS'(mag_q) * PROD_BITS'(K_INV);
    m_g  = $signed(WORK_BITS'(prod >> (K_INV_SHIFT - GUARD_BITS)));
    fold = phase_q[PHASE_BITS-1] ^ phase_q[PHASE_BITS-2];
    x0   = fold ? -m_g : m_g;
    z_ph = {phase_q[PHASE_BITS-1] ^ fold, phase_q[PHASE_BITS-2:0]};
    z0   = Z_BITS'($signed({z_ph, {Z_FRAC_BITS{1'b0}}}));

    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    atan_step = Z_BITS'(ATAN[iter_q]);
    if (!z_q[Z_BITS-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_step;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (input_ready) begin
            mag_q   <= magnitude;
            phase_q <= phase;
            busy_q  <= 1'b1;
            state_q <= PRESCALE;
          end
        end
        PRESCALE: begin
          x_q     <= x0;
          y_q     <= '0;
          z_q     <= z0;
          iter_q  <= '0;
          state_q <= ROTATE;
        end
        ROTATE: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 1'b1;
          // Results are registered on the last micro-rotation so they are valid during DONE
          if (iter_q == LAST_ITER) begin
            out1_q  <= sat_out(x_d);
            out2_q  <= sat_out(y_d);
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign output_ready = ready_q;
  assign output_1     = out1_q;
  assign output_2     = out2_q;

endmodule

// File: tb/tb_polar_to_rect.sv
// tb/tb_polar_to_rect.sv - self-checking bench for polar_to_rect against an ideal trigonometric model
module tb_polar_to_rect;

  localparam real TWO_PI = 6.283185307179586;
  localparam int  LAT    = 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               input_ready;
  logic [16:0]        magnitude;
  logic [15:0]        phase;
  logic               busy;
  logic               output_ready;
  logic signed [17:0] output_1;
  logic signed [17:0] output_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  polar_to_rect dut (
    .clk          (clk),
    .rst          (rst),
    .input_ready  (input_ready),
    .magnitude    (magnitude),
    .phase        (phase),
    .busy         (busy),
    .output_ready (output_ready),
    .output_1     (output_1),
    .output_2     (output_2)
  );

  function automatic int ideal_i(int mag, int ph);
    return int'(real'(mag) * $cos(TWO_PI * real'(ph) / 65536.0));
  endfunction

  function automatic int ideal_q(int mag, int ph);
    return int'(real'(mag) * $sin(TWO_PI * real'(ph) / 65536.0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one sample and waits (bounded) for its result; returns at the cycle after output_ready
  task automatic convert(input int mag, input int ph, output int o1, output int o2,
                         output int lat, output int busy_cnt);
    lat = -1; busy_cnt = 0; o1 = 0; o2 = 0;
    input_ready = 1'b1;
    magnitude   = 17'(mag);
    phase       = 16'(ph);
    step();
    input_ready = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      if (busy) busy_cnt++;
      if (output_ready) begin
        lat = c;
        o1  = int'(output_1);
        o2  = int'(output_2);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; input_ready = 1'b0; magnitude = '0; phase = '0;
    #2 rst = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", output_ready); end
    checks++; if (output_1 !== 18'sd0) begin errors++; $display("FAIL reset_out1: got %0d want 0", output_1); end
    checks++; if (output_2 !== 18'sd0) begin errors++; $display("FAIL reset_out2: got %0d want 0", output_2); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_latency_busy();
    int o1, o2, lat, bc;
    convert(10000, 'h0000, o1, o2, lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
    checks++; if (bc !== LAT) begin errors++; $display("FAIL busy_cycles: got %0d want %0d", bc, LAT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", busy); end
    checks++; if (o1 - 10000 > 4 || o1 - 10000 < -4) begin errors++; $display("FAIL phase0_i: got %0d want 10000+-4", o1); end
    checks++; if (o2 > 4 || o2 < -4) begin errors++; $display("FAIL phase0_q: got %0d want 0+-4", o2); end
  endtask

  task automatic test_quadrants();
    int mags [8] = '{10000, 10000, 10000, 131071, 0, 0, 50000, 131071};
    int phs  [8] = '{'h4000, 'h8000, 'hC000, 'hE000, 'h1234, 'hC321, 'h2000, 'h0000};
    int o1, o2, lat, bc, e1, e2, tol;
    for (int k = 0; k < 8; k++) begin
      convert(mags[k], phs[k], o1, o2, lat, bc);
      e1  = ideal_i(mags[k], phs[k]);
      e2  = ideal_q(mags[k], phs[k]);
      tol = (mags[k] == 0) ? 0 : 4;
      checks++; if (lat !== LAT) begin errors++; $display("FAIL quad%0d_latency: got %0d want %0d", k, lat, LAT); end
      checks++; if (o1 - e1 > tol || o1 - e1 < -tol) begin errors++; $display("FAIL quad%0d_i: got %0d want %0d+-%0d", k, o1, e1, tol); end
      checks++; if (o2 - e2 > tol || o2 - e2 < -tol) begin errors++; $display("FAIL quad%0d_q: got %0d want %0d+-%0d", k, o2, e2, tol); end
    end
  endtask

  task automatic test_back_to_back();
    int ready_cyc [$];
    int got1 [$];
    int got2 [$];
    int a1, a2, e1, e2;
    a1 = ideal_i(20000, 'h1555); a2 = ideal_q(20000, 'h1555);
    e1 = ideal_i(30000, 'h9ABC); e2 = ideal_q(30000, 'h9ABC);
    for (int c = 0; c <= 45; c++) begin
      if (output_ready) begin
        ready_cyc.push_back(c);
        got1.push_back(int'(output_1));
        got2.push_back(int'(output_2));
      end
      if (c == 19) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coincident_pulse_ignored: busy got %b want 0", busy); end
      end
      if (c == 20) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_pulse_accepted: busy got %b want 1", busy); end
      end
      if (c == 30) begin
        checks++; if (int'(output_1) - a1 > 4 || int'(output_1) - a1 < -4) begin errors++; $display("FAIL output_hold: got %0d want %0d+-4", output_1, a1); end
      end
      input_ready = (c == 0 || c == 3 || c == 17 || c == 18 || c == 19);
      magnitude   = (c == 0) ? 17'd20000 : (c == 19) ? 17'd30000 : 17'($urandom_range(1, 131071));
      phase       = (c == 0) ? 16'h1555  : (c == 19) ? 16'h9ABC  : 16'($urandom);
      step();
    end
    input_ready = 1'b0;
    checks++; if (ready_cyc.size() != 2) begin errors++; $display("FAIL b2b_ready_count: got %0d want 2", ready_cyc.size()); end
    if (ready_cyc.size() >= 1) begin
      checks++; if (ready_cyc[0] != LAT) begin errors++; $display("FAIL b2b_first_cycle: got %0d want %0d", ready_cyc[0], LAT); end
      checks++; if (got1[0] - a1 > 4 || got1[0] - a1 < -4 || got2[0] - a2 > 4 || got2[0] - a2 < -4) begin
        errors++; $display("FAIL b2b_first_value: got (%0d,%0d) want (%0d,%0d)+-4", got1[0], got2[0], a1, a2);
      end
    end
    if (ready_cyc.size() >= 2) begin
      checks++; if (ready_cyc[1] != 19 + LAT) begin errors++; $display("FAIL b2b_second_cycle: got %0d want %0d", ready_cyc[1], 19 + LAT); end
      checks++; if (got1[1] - e1 > 4 || got1[1] - e1 < -4 || got2[1] - e2 > 4 || got2[1] - e2 < -4) begin
        errors++; $display("FAIL b2b_second_value: got (%0d,%0d) want (%0d,%0d)+-4", got1[1], got2[1], e1, e2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int o1, o2, lat, bc, seen_ready, seen_busy, e1, e2;
    input_ready = 1'b1; magnitude = 17'd40000; phase = 16'h3000;
    step();
    input_ready = 1'b0;
    for (int c = 1; c < 8; c++) step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (output_1 !== 18'sd0 || output_2 !== 18'sd0) begin errors++; $display("FAIL midreset_outputs: got (%0d,%0d) want (0,0)", output_1, output_2); end
    step();
    step();
    rst = 1'b1;
    seen_ready = 0; seen_busy = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (output_ready) seen_ready++;
      if (busy) seen_busy++;
    end
    checks++; if (seen_ready != 0) begin errors++; $display("FAIL midreset_no_ready: got %0d pulses want 0", seen_ready); end
    checks++; if (seen_busy != 0) begin errors++; $display("FAIL midreset_idle: got %0d busy cycles want 0", seen_busy); end
    convert(25000, 'h6000, o1, o2, lat, bc);
    e1 = ideal_i(25000, 'h6000); e2 = ideal_q(25000, 'h6000);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL after_reset_latency: got %0d want %0d", lat, LAT); end
    checks++; if (o1 - e1 > 4 || o1 - e1 < -4 || o2 - e2 > 4 || o2 - e2 < -4) begin
      errors++; $display("FAIL after_reset_value: got (%0d,%0d) want (%0d,%0d)+-4", o1, o2, e1, e2);
    end
  endtask

  // Round trip: random I/Q -> ideal magnitude/phase -> DUT -> compare with the ideal and with the source I/Q
  task automatic test_random();
    int i_src, q_src, mag, ph, o1, o2, lat, bc, e1, e2;
    for (int k = 0; k < 20; k++) begin
      i_src = int'($urandom_range(0, 65535)) - 32768;
      q_src = int'($urandom_range(0, 65535)) - 32768;
      mag   = int'($sqrt(real'(i_src) * real'(i_src) + real'(q_src) * real'(q_src)));
      ph    = int'($atan2(real'(q_src), real'(i_src)) * 65536.0 / TWO_PI);
      if (ph < 0) ph += 65536;
      if (ph >= 65536) ph -= 65536;
      convert(mag, ph, o1, o2, lat, bc);
      e1 = ideal_i(mag, ph);
      e2 = ideal_q(mag, ph);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, LAT); end
      checks++; if (o1 - e1 > 4 || o1 - e1 < -4 || o2 - e2 > 4 || o2 - e2 < -4) begin
        errors++; $display("FAIL rand%0d_ideal: got (%0d,%0d) want (%0d,%0d)+-4", k, o1, o2, e1, e2);
      end
      checks++; if (o1 - i_src > 8 || o1 - i_src < -8 || o2 - q_src > 8 || o2 - q_src < -8) begin
        errors++; $display("FAIL rand%0d_roundtrip: got (%0d,%0d) want (%0d,%0d)+-8", k, o1, o2, i_src, q_src);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_busy();
    test_quadrants();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
